// File: rtl/vacc_baseline_reader.sv
//------------------------------------------------------------------------------
// vacc_baseline_reader: scans antenna pairs of a completed accumulator buffer
// and streams tagged signed products. Optional: VACC_READER_CROSS_ONLY_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module vacc_baseline_reader #(
  parameter int ACC_WIDTH       = 12,
  parameter int VECTOR_LENGTH   = 32,
  localparam int VECTOR_LEN_BITS = $clog2(VECTOR_LENGTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          trig,
  input  logic                          trig_buf,
  output logic [VECTOR_LEN_BITS-1:0]    ant_sel_a,
  output logic [VECTOR_LEN_BITS-1:0]    ant_sel_b,
  output logic                          buf_sel,
  input  logic signed [ACC_WIDTH-1:0]   din_a,
  input  logic signed [ACC_WIDTH-1:0]   din_b,
  output logic signed [2*ACC_WIDTH-1:0] prod_out,
  output logic                          prod_valid,
  output logic [VECTOR_LEN_BITS-1:0]    prod_ant_a,
  output logic [VECTOR_LEN_BITS-1:0]    prod_ant_b,
  output logic                          prod_last,
  output logic                          busy,
  output logic                          overflow
);

  localparam logic [VECTOR_LEN_BITS-1:0] ANT_MAX = VECTOR_LEN_BITS'(VECTOR_LENGTH - 1);
`ifdef VACC_READER_CROSS_ONLY_EN
  localparam logic [VECTOR_LEN_BITS-1:0] FIRST_B  = VECTOR_LEN_BITS'(1);
  localparam logic [VECTOR_LEN_BITS-1:0] LAST_A   = VECTOR_LEN_BITS'(VECTOR_LENGTH - 2);
  localparam logic [VECTOR_LEN_BITS-1:0] ROW_STEP = VECTOR_LEN_BITS'(2);
`else
  localparam logic [VECTOR_LEN_BITS-1:0] FIRST_B  = VECTOR_LEN_BITS'(0);
  localparam logic [VECTOR_LEN_BITS-1:0] LAST_A   = VECTOR_LEN_BITS'(VECTOR_LENGTH - 1);
  localparam logic [VECTOR_LEN_BITS-1:0] ROW_STEP = VECTOR_LEN_BITS'(1);
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                                 state_q, state_d;
  logic [VECTOR_LEN_BITS-1:0]             a_q, a_d, b_q, b_d;
  logic                                   buf_sel_q, buf_sel_d;
  logic                                   overflow_q, overflow_d;
  logic [2:0]                             vld_q, vld_d;
  logic [2:0]                             last_q, last_d;
  logic [2:0][VECTOR_LEN_BITS-1:0]        tag_a_q, tag_a_d, tag_b_q, tag_b_d;
  logic signed [2*ACC_WIDTH-1:0]          prod_q, prod_d;
  logic signed [2*ACC_WIDTH-1:0]          ext_a, ext_b;
  logic                                   issue, last_issue;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    buf_sel_d  = buf_sel_q;
    overflow_d = overflow_q | (trig && (state_q != IDLE));
    issue      = (state_q == SCAN);
    last_issue = issue && (a_q == LAST_A) && (b_q == ANT_MAX);

    case (state_q)
      IDLE: begin
        if (trig) begin
          buf_sel_d = trig_buf;
          a_d       = '0;
          b_d       = FIRST_B;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        // The final pair stays on the address bus through DRAIN.
        if (last_issue) begin
          state_d = DRAIN;
        end else if (b_q != ANT_MAX) begin
          b_d = b_q + VECTOR_LEN_BITS'(1);
        end else begin
          a_d = a_q + VECTOR_LEN_BITS'(1);
          b_d = a_q + ROW_STEP;
        end
      end
      DRAIN: begin
        if (vld_q[2] && last_q[2]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Tag pipeline: stage 0 lines up with the BRAM address register, stage 2
  // with the product register, so tags leave together with their product.
  always_comb begin
    vld_d   = {vld_q[1:0], issue};
    last_d  = {last_q[1:0], last_issue};
    tag_a_d = {tag_a_q[1:0], a_q};
    tag_b_d = {tag_b_q[1:0], b_q};
    ext_a   = (2*ACC_WIDTH)'(din_a);
    ext_b   = (2*ACC_WIDTH)'(din_b);
    prod_d  = vld_q[1] ? (ext_a * ext_b) : prod_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      buf_sel_q  <= 1'b0;
      overflow_q <= 1'b0;
      vld_q      <= '0;
      last_q     <= '0;
      tag_a_q    <= '0;
      tag_b_q    <= '0;
      prod_q     <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      buf_sel_q  <= buf_sel_d;
      overflow_q <= overflow_d;
      vld_q      <= vld_d;
      last_q     <= last_d;
      tag_a_q    <= tag_a_d;
      tag_b_q    <= tag_b_d;
      prod_q     <= prod_d;
    end
  end

  assign ant_sel_a  = a_q;
  assign ant_sel_b  = b_q;
  assign buf_sel    = buf_sel_q;
  assign prod_out   = prod_q;
  assign prod_valid = vld_q[2];
  assign prod_last  = vld_q[2] & last_q[2];
  assign prod_ant_a = tag_a_q[2];
  assign prod_ant_b = tag_b_q[2];
  assign busy       = (state_q != IDLE);
  assign overflow   = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_vacc_baseline_reader.sv
//------------------------------------------------------------------------------
// tb_vacc_baseline_reader: bench for vacc_baseline_reader with N=4, W=12 and a
// two-buffer, 2-cycle-latency accumulator memory model.
//------------------------------------------------------------------------------
`default_nettype none

module tb_vacc_baseline_reader;

  localparam int N  = 4;
  localparam int W  = 12;
  localparam int LB = 2;
`ifdef VACC_READER_CROSS_ONLY_EN
  localparam int XOFF = 1;
`else
  localparam int XOFF = 0;
`endif
  localparam int NPAIRS = (N - XOFF) * (N - XOFF + 1) / 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst, trig, trig_buf;
  logic [LB-1:0]         ant_sel_a, ant_sel_b, prod_ant_a, prod_ant_b;
  logic                  buf_sel, prod_valid, prod_last, busy, overflow;
  logic signed [W-1:0]   din_a = '0, din_b = '0, rd_a = '0, rd_b = '0;
  logic signed [2*W-1:0] prod_out;

  vacc_baseline_reader #(.ACC_WIDTH(W), .VECTOR_LENGTH(N)) dut (
    .clk(clk), .rst(rst), .trig(trig), .trig_buf(trig_buf),
    .ant_sel_a(ant_sel_a), .ant_sel_b(ant_sel_b), .buf_sel(buf_sel),
    .din_a(din_a), .din_b(din_b), .prod_out(prod_out), .prod_valid(prod_valid),
    .prod_ant_a(prod_ant_a), .prod_ant_b(prod_ant_b), .prod_last(prod_last),
    .busy(busy), .overflow(overflow)
  );

  // Accumulator memory: two buffers, address registered then data registered.
  int mem [2][N];
  always @(posedge clk) begin
    rd_a  <= W'(mem[buf_sel][ant_sel_a]);
    rd_b  <= W'(mem[buf_sel][ant_sel_b]);
    din_a <= rd_a;
    din_b <= rd_b;
  end

  typedef struct {
    int     a;
    int     b;
    longint p;
    bit     last;
  } exp_t;

  typedef struct {
    bit     tbuf;
    int     fill;
    longint p03;
    longint p00;
    longint p11;
  } vec_t;

  exp_t   expq[$];
  int     seq[$];
  int     exp_order[$];
  vec_t   vecs[3];
  longint cap[N][N];
  int     errors = 0, checks = 0, cyc = 0;
  int     nvalid, nlast, first_cyc, last_cyc;
  bit     busy_s, cur_buf, ov_model;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    busy_s = busy;
    if (busy) check("buf_sel_hold", buf_sel, cur_buf);
    if (prod_valid) begin
      nvalid++;
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
      if (prod_last) nlast++;
      seq.push_back(int'(prod_ant_a) * N + int'(prod_ant_b));
      cap[prod_ant_a][prod_ant_b] = longint'(prod_out);
      if (expq.size() == 0) begin
        check("unexpected_prod_valid", 1, 0);
      end else begin
        e = expq.pop_front();
        check("tag_a", prod_ant_a, e.a);
        check("tag_b", prod_ant_b, e.b);
        check("product", longint'(prod_out), e.p);
        check("prod_last", prod_last, e.last);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic fill(input int bsel, input int mode);
    for (int i = 0; i < N; i++) begin
      case (mode)
        0:       mem[bsel][i] = 3 * i - 5;
        1:       mem[bsel][i] = -2048;
        2:       mem[bsel][i] = (i == 0) ? 2047 : -2048;
        default: mem[bsel][i] = int'($urandom_range(0, 4095)) - 2048;
      endcase
    end
  endtask

  // Reference: every pair a<=b (a<b when cross-only) in row-major order.
  task automatic prep(input bit tb);
    exp_t e;
    expq.delete();
    seq.delete();
    for (int a = 0; a < N; a++) begin
      for (int b = 0; b < N; b++) cap[a][b] = 64'h7fff_ffff_ffff_ffff;
      for (int b = a + XOFF; b < N; b++) begin
        e.a = a;
        e.b = b;
        e.p = longint'(mem[tb][a]) * longint'(mem[tb][b]);
        e.last = 1'b0;
        expq.push_back(e);
      end
    end
    if (expq.size() > 0) expq[expq.size() - 1].last = 1'b1;
    nvalid = 0; nlast = 0; first_cyc = -1; last_cyc = -1;
    cur_buf = tb;
  endtask

  task automatic run_scan(input bit tb, input int ov1, input int ov2);
    int start, fall, exp_n;
    prep(tb);
    exp_n = expq.size();
    start = cyc;
    trig = 1'b1;
    trig_buf = tb;
    tick();
    trig = 1'b0;
    trig_buf = ~tb;
    fall = -1;
    for (int k = 1; k <= 4 * N * N + 20; k++) begin
      trig = (k == ov1) || (k == ov2);
      tick();
      if (!busy_s) begin
        fall = cyc - 1;
        break;
      end
    end
    trig = 1'b0;
    if (ov1 > 0 || ov2 > 0) ov_model = 1'b1;
    check("scan_length", fall - start, exp_n + 4);
    check("prod_count", nvalid, exp_n);
    check("last_count", nlast, 1);
    check("first_latency", first_cyc - start, 4);
    check("busy_after_last", fall - last_cyc, 1);
    check("model_leftover", expq.size(), 0);
    check("overflow", overflow, ov_model);
    check("hold_ant_a", ant_sel_a, N - 1 - XOFF);
    check("hold_ant_b", ant_sel_b, N - 1);
  endtask

  initial begin
    int start, ov1;
    bit tb;
`ifdef VACC_READER_CROSS_ONLY_EN
    exp_order = '{1, 2, 3, 6, 7, 11};
`else
    exp_order = '{0, 1, 2, 3, 5, 6, 7, 10, 11, 15};
`endif
    vecs[0] = '{1'b1, 0, -20, 25, 4};
    vecs[1] = '{1'b0, 1, 4194304, 4194304, 4194304};
    vecs[2] = '{1'b1, 2, -4192256, 4190209, 4194304};

    rst = 1'b1; trig = 1'b0; trig_buf = 1'b0;
    fill(0, 3); fill(1, 3);
    ov_model = 1'b0; cur_buf = 1'b0;
    nvalid = 0; nlast = 0; first_cyc = -1; last_cyc = -1;
    repeat (2) tick();
    check("rst_prod_valid", prod_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_ant_sel", {ant_sel_a, ant_sel_b}, 0);
    check("rst_buf_sel", buf_sel, 0);
    check("rst_prod_out", prod_out, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 3; i++) begin
      fill(int'(vecs[i].tbuf), vecs[i].fill);
      fill(int'(!vecs[i].tbuf), 3);
      run_scan(vecs[i].tbuf, 0, 0);
      check("tbl_p03", cap[0][3], vecs[i].p03);
`ifdef VACC_READER_CROSS_ONLY_EN
      check("tbl_no_diag", cap[0][0], 64'h7fff_ffff_ffff_ffff);
      check("tbl_no_diag", cap[1][1], 64'h7fff_ffff_ffff_ffff);
`else
      check("tbl_p00", cap[0][0], vecs[i].p00);
      check("tbl_p11", cap[1][1], vecs[i].p11);
`endif
      if (i == 0) begin
        check("order_len", seq.size(), exp_order.size());
        for (int j = 0; j < seq.size() && j < exp_order.size(); j++)
          check("order", seq[j], exp_order[j]);
      end
    end

    // trig during SCAN and during DRAIN, then a new scan right after busy falls
    fill(0, 0); fill(1, 3);
    run_scan(1'b0, 3, NPAIRS + 2);
    run_scan(1'b1, 0, 0);

    // asynchronous reset while the fifth pair is on the address bus
    prep(1'b1);
    trig = 1'b1; trig_buf = 1'b1;
    tick();
    trig = 1'b0;
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    check("arst_prod_valid", prod_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_overflow", overflow, 0);
    check("arst_ant_sel", {ant_sel_a, ant_sel_b, buf_sel}, 0);
    check("arst_prod", {prod_out, prod_last, prod_ant_a, prod_ant_b}, 0);
    expq.delete();
    ov_model = 1'b0;
    nvalid = 0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (8) tick();
    check("no_residual_valid", nvalid, 0);
    run_scan(1'b1, 0, 0);

    for (int r = 0; r < 6; r++) begin
      fill(0, 3); fill(1, 3);
      tb = 1'($urandom);
      ov1 = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, NPAIRS + 3)) : 0;
      run_scan(tb, ov1, 0);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
